// File: rtl/verin_pkg.sv
// Package for the verin PWM drive stage.
// Holds the FSM state encoding, duty/phase widths and the field positions
// of the 8-bit PIO command word.
package verin_pkg;

    localparam int          DUTY_W       = 7;
    localparam logic [6:0]  PHASE_MAX    = 7'd127;
    localparam int          CMD_DIR_BIT  = 7;
    localparam int          CMD_DUTY_MSB = 6;

    // Encoding is visible on state_out for PIO readback.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

endpackage

// File: rtl/verin_pwm_ctrl_if.sv
// Command/status bundle between the Avalon PIO and the verin drive stage.
//   cmd           PIO command word: [7] direction, [6:0] duty
//   pwm_out       PWM drive to the bridge enable
//   dir_out       direction to the bridge
//   state_out     FSM state readback (00 IDLE, 01 RUN, 10 DEAD)
//   period_strobe one-clk pulse at each PWM period boundary
// master = PIO side (drives cmd), slave = drive stage.
interface verin_pwm_ctrl_if;
    logic [7:0] cmd;
    logic       pwm_out;
    logic       dir_out;
    logic [1:0] state_out;
    logic       period_strobe;

    modport master (output cmd, input pwm_out, dir_out, state_out, period_strobe);
    modport slave  (input cmd, output pwm_out, dir_out, state_out, period_strobe);
endinterface

// File: rtl/verin_pwm_tick.sv
// Prescaler plus 7-bit PWM phase counter.
//   clk, reset_n  clock, asynchronous active-low reset
//   tick_o        one clk every CLK_DIV clks (prescaler terminal count)
//   phase_o       current PWM phase 0..127, advances on tick
//   boundary_o    tick on the last phase: end of a PWM period
module verin_pwm_tick
    import verin_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              tick_o,
    output logic [DUTY_W-1:0] phase_o,
    output logic              boundary_o
);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [DUTY_W-1:0] phase_q, phase_d;

    always_comb begin
        tick_o     = (pre_cnt_q == PW'(CLK_DIV - 1));
        pre_cnt_d  = tick_o ? '0 : pre_cnt_q + 1'b1;
        // 7-bit counter wraps 127 -> 0 naturally.
        phase_d    = tick_o ? phase_q + 1'b1 : phase_q;
        boundary_o = tick_o && (phase_q == PHASE_MAX);
        phase_o    = phase_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            phase_q   <= phase_d;
        end
    end
endmodule

// File: rtl/verin_pwm_ctrl.sv
// Verin (cylinder) drive stage fed by the PIO command register.
// Produces a period-synchronous PWM plus direction for an H-bridge and
// forces a dead-time of DEAD_PERIODS full periods on every direction reversal.
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           verin_pwm_ctrl_if.slave: cmd in; pwm_out, dir_out,
//                 state_out, period_strobe out
// Optional feature macro: SOFT_RAMP_EN (duty ramps +/-1 per period in RUN).
module verin_pwm_ctrl
    import verin_pkg::*;
#(
    parameter int CLK_DIV      = 50,
    parameter int DEAD_PERIODS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    verin_pwm_ctrl_if.slave bus
);
    localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    logic              tick, boundary;
    logic [DUTY_W-1:0] phase;

    verin_pwm_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_o     (tick),
        .phase_o    (phase),
        .boundary_o (boundary)
    );

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic [DW-1:0]     dead_q, dead_d;
    logic              pwm_q, pwm_d;
    logic              strobe_q;
    logic              upd_q;

    logic              cmd_dir;
    logic [DUTY_W-1:0] cmd_duty;

    assign cmd_dir  = bus.cmd[CMD_DIR_BIT];
    assign cmd_duty = bus.cmd[CMD_DUTY_MSB:0];

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        if (boundary) begin
            case (state_q)
                ST_IDLE: begin
                    dir_d = cmd_dir;
                    if (cmd_duty != '0) begin
                        state_d = ST_RUN;
`ifdef SOFT_RAMP_EN
                        duty_d  = DUTY_W'(1);
`else
                        duty_d  = cmd_duty;
`endif
                    end
                end
                ST_RUN: begin
`ifdef SOFT_RAMP_EN
                    // Reversal: ramp to zero first, only then start the dead-time.
                    if (cmd_dir != dir_q) begin
                        if (duty_q != '0) begin
                            duty_d = duty_q - 1'b1;
                        end else begin
                            state_d = ST_DEAD;
                            dead_d  = DW'(DEAD_PERIODS - 1);
                        end
                    end else if (cmd_duty == '0 && duty_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (cmd_duty > duty_q) begin
                        duty_d = duty_q + 1'b1;
                    end else if (cmd_duty < duty_q) begin
                        duty_d = duty_q - 1'b1;
                    end
`else
                    if (cmd_dir != dir_q) begin
                        state_d = ST_DEAD;
                        duty_d  = '0;
                        dead_d  = DW'(DEAD_PERIODS - 1);
                    end else if (cmd_duty == '0) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                    end else begin
                        duty_d  = cmd_duty;
                    end
`endif
                end
                ST_DEAD: begin
                    // Full dead-time runs out even if cmd flips back meanwhile.
                    if (dead_q != '0) begin
                        dead_d = dead_q - 1'b1;
                    end else begin
                        dir_d = cmd_dir;
                        if (cmd_duty != '0) begin
                            state_d = ST_RUN;
`ifdef SOFT_RAMP_EN
                            duty_d  = DUTY_W'(1);
`else
                            duty_d  = cmd_duty;
`endif
                        end else begin
                            state_d = ST_IDLE;
                            duty_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    // Duty 127 is forced fully on; otherwise high while phase < duty.
    assign pwm_d = (state_q == ST_RUN) && ((duty_q == PHASE_MAX) || (phase < duty_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            dir_q    <= 1'b0;
            dead_q   <= '0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            dead_q   <= dead_d;
            strobe_q <= boundary;
            // Phase/state only move on tick, so the PWM compare needs
            // re-evaluating just on the clk after a tick.
            upd_q    <= tick;
            if (upd_q) pwm_q <= pwm_d;
        end
    end

    assign bus.pwm_out       = pwm_q;
    assign bus.dir_out       = dir_q;
    assign bus.state_out     = state_q;
    assign bus.period_strobe = strobe_q;
endmodule

// File: tb/tb_verin_pwm_ctrl.sv
// Directed bench for verin_pwm_ctrl with CLK_DIV=2, DEAD_PERIODS=2
// (one PWM period = 256 clk). Outputs are sampled on the falling edge.
module tb_verin_pwm_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    verin_pwm_ctrl_if bus ();

    verin_pwm_ctrl #(.CLK_DIV(2), .DEAD_PERIODS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full period sampled right after a strobe: ends on the next strobe.
    task automatic win(output int hi, output int st);
        hi = 0; st = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pwm_out) hi++;
            if (bus.period_strobe) st++;
        end
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (bus.period_strobe) break;
        end
    endtask

    int hi, st, cyc, rises;
    logic prev;

    initial begin
        bus.cmd = 8'h00;
        repeat (3) @(negedge clk);
        // 1. reset state and idle periods
        check("rst_pwm",    bus.pwm_out, 0);
        check("rst_dir",    bus.dir_out, 0);
        check("rst_state",  bus.state_out, 0);
        check("rst_strobe", bus.period_strobe, 0);
        reset_n = 1'b1;
        wait_strobe(cyc);
        check("first_boundary", cyc, 256);
        for (int p = 0; p < 4; p++) begin
            win(hi, st);
            check("idle_hi", hi, 0);
            check("idle_strobe", st, 1);
        end
        check("idle_state", bus.state_out, 0);
        check("idle_dir", bus.dir_out, 0);

        // 2. duty 32
        bus.cmd = 8'h20;
        win(hi, st);
        check("pre_run_hi", hi, 0);
        check("run_state", bus.state_out, 1);
        win(hi, st);
        check("d32_hi", hi, 64);
        check("d32_dir", bus.dir_out, 0);
        win(hi, st);
        check("d32_hi2", hi, 64);

        // 3. full on, then off
        bus.cmd = 8'h7F;
        win(hi, st);
        check("d32_hi3", hi, 64);
        win(hi, st);
        check("d127_hi", hi, 256);
        bus.cmd = 8'h00;
        win(hi, st);
        check("d127_hold", hi, 256);
        check("to_idle", bus.state_out, 0);
        win(hi, st);
        check("off_hi", hi, 0);

        // 4. reversal with dead-time
        bus.cmd = 8'h40;
        win(hi, st);
        check("run64_state", bus.state_out, 1);
        win(hi, st);
        check("d64_hi", hi, 128);
        bus.cmd = 8'hC0;
        win(hi, st);
        check("d64_hold", hi, 128);
        check("dead_state", bus.state_out, 2);
        check("dead_dir", bus.dir_out, 0);
        win(hi, st);
        check("dead1_hi", hi, 0);
        check("dead1_state", bus.state_out, 2);
        check("dead1_dir", bus.dir_out, 0);
        win(hi, st);
        check("dead2_hi", hi, 0);
        check("rev_state", bus.state_out, 1);
        check("rev_dir", bus.dir_out, 1);
        win(hi, st);
        check("rev_hi", hi, 128);

        // 5. mid-period command changes are ignored
        bus.cmd = 8'h90;
        win(hi, st);
        win(hi, st);
        check("d16_hi", hi, 32);
        hi = 0; rises = 0; prev = bus.pwm_out;
        for (int i = 0; i < 256; i++) begin
            if (i == 50)  bus.cmd = 8'hB0;
            if (i == 120) bus.cmd = 8'h90;
            @(negedge clk);
            if (bus.pwm_out) hi++;
            if (bus.pwm_out && !prev) rises++;
            prev = bus.pwm_out;
        end
        check("glitch_hi", hi, 32);
        check("glitch_rises", rises, 1);
        win(hi, st);
        check("d16_after", hi, 32);

        // 6. asynchronous reset mid-RUN
        repeat (10) @(negedge clk);
        check("pre_rst_pwm", bus.pwm_out, 1);
        reset_n = 1'b0;
        #1;
        check("arst_pwm",   bus.pwm_out, 0);
        check("arst_state", bus.state_out, 0);
        check("arst_dir",   bus.dir_out, 0);
        bus.cmd = 8'h20;
        @(negedge clk);
        reset_n = 1'b1;
        wait_strobe(cyc);
        check("rst_boundary", cyc, 256);
        check("rst_run", bus.state_out, 1);
        win(hi, st);
        check("rst_d32_hi", hi, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
